// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package booth_pkg;

    typedef logic [1:0] booth_state_t;

    localparam booth_state_t IDLE = 2'd0;
    localparam booth_state_t CALC = 2'd1;
    localparam booth_state_t DONE = 2'd2;

    // Booth group {b[2i+1], b[2i], b[2i-1]} encodings
    localparam logic [2:0] GRP_ZERO_LO = 3'b000;
    localparam logic [2:0] GRP_PA_LO   = 3'b001;
    localparam logic [2:0] GRP_PA_HI   = 3'b010;
    localparam logic [2:0] GRP_P2A     = 3'b011;
    localparam logic [2:0] GRP_M2A     = 3'b100;
    localparam logic [2:0] GRP_MA_LO   = 3'b101;
    localparam logic [2:0] GRP_MA_HI   = 3'b110;
    localparam logic [2:0] GRP_ZERO_HI = 3'b111;

    // Unsigned needs one extra group to absorb the zero-extended top bits.
    function automatic int booth_iters(input int width, input logic is_signed);
        return is_signed ? (width / 2) : (width / 2 + 1);
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product selector; negative terms leave as one's
// complement plus a separate carry bit for the accumulator adder.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a_ext_i,
    input  logic [2:0]       group_i,
    output logic [WIDTH+1:0] pp_o,
    output logic             neg_o
);
    logic [WIDTH+1:0] aWide;
    logic [WIDTH+1:0] aTwice;

    assign aWide  = {a_ext_i[WIDTH], a_ext_i};
    assign aTwice = {a_ext_i, 1'b0};

    always_comb begin
        pp_o  = '0;
        neg_o = 1'b0;
        case (group_i)
            GRP_PA_LO, GRP_PA_HI: pp_o = aWide;
            GRP_P2A:              pp_o = aTwice;
            GRP_M2A: begin
                pp_o  = ~aTwice;
                neg_o = 1'b1;
            end
            GRP_MA_LO, GRP_MA_HI: begin
                pp_o  = ~aWide;
                neg_o = 1'b1;
            end
            default:              pp_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one partial product per clock into a
// 2*WIDTH accumulator, signed or unsigned operands selected per transaction.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               is_signed_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] p_o
);
    localparam int IDXW = $clog2(WIDTH / 2 + 2);
    localparam int PW   = 2 * WIDTH;

    booth_state_t     state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH+2:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [PW-1:0]    acc_q, acc_d;

    logic [WIDTH+1:0] pp;
    logic             ppNeg;
    logic [PW-1:0]    ppExt, ppShift, lowFill, addend;
    logic [IDXW:0]    shamt;
    logic [IDXW-1:0]  lastIdx;
    logic             extA, extB;

    // b_q holds {b extended, b[-1]=0} and shifts right two bits per group,
    // so the current group is always its three lowest bits.
    booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .a_ext_i (a_q),
        .group_i (b_q[2:0]),
        .pp_o    (pp),
        .neg_o   (ppNeg)
    );

    assign extA    = is_signed_i & a_i[WIDTH-1];
    assign extB    = is_signed_i & b_i[WIDTH-1];
    assign shamt   = {idx_q, 1'b0};
    assign ppExt   = {{(PW - WIDTH - 2){pp[WIDTH+1]}}, pp};
    assign ppShift = ppExt << shamt;
    assign lowFill = ~({PW{1'b1}} << shamt);
    // Filling the shifted-in zeros with ones keeps the whole term a one's
    // complement, so the +1 carry belongs at accumulator bit 0.
    assign addend  = ppNeg ? (ppShift | lowFill) : ppShift;
    assign lastIdx = IDXW'(booth_iters(WIDTH, signed_q) - 1);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d      = {extA, a_i};
                    b_d      = {extB, extB, b_i, 1'b0};
                    signed_d = is_signed_i;
                    idx_d    = '0;
                    acc_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + addend + PW'(ppNeg);
                b_d   = {{2{b_q[WIDTH+2]}}, b_q[WIDTH+2:2]};
                idx_d = idx_q + IDXW'(1);
                if (idx_q == lastIdx) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign p_o         = acc_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult at WIDTH=8 and WIDTH=16: directed
// vectors, back-pressure and reset-abort sequences, then randomized pairs.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] aIn = '0;
    logic [15:0] bIn = '0;
    logic        sgnIn = 1'b0;
    logic        outReady = 1'b0;
    logic        inValid8 = 1'b0;
    logic        inValid16 = 1'b0;
    logic        inReady8, outValid8, inReady16, outValid16;
    logic [15:0] p8;
    logic [31:0] p16;

    always #5 clk = ~clk;

    booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (inValid8),
        .in_ready_o  (inReady8),
        .a_i         (aIn[7:0]),
        .b_i         (bIn[7:0]),
        .is_signed_i (sgnIn),
        .out_valid_o (outValid8),
        .out_ready_i (outReady),
        .p_o         (p8)
    );

    booth_seq_mult #(.WIDTH(16)) dut16 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (inValid16),
        .in_ready_o  (inReady16),
        .a_i         (aIn),
        .b_i         (bIn),
        .is_signed_i (sgnIn),
        .out_valid_o (outValid16),
        .out_ready_i (outReady),
        .p_o         (p16)
    );

    typedef struct {
        int          w;
        logic [15:0] a;
        logic [15:0] b;
        logic        sg;
        logic [31:0] expP;
        int          expLat;
    } vec_t;

    vec_t vecs[$];
    int   checksTotal = 0;
    int   checksPassed = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference: interpret operands as integers and multiply with plain arithmetic.
    function automatic logic [31:0] refMul(input int w, input logic [15:0] av, input logic [15:0] bv, input logic sg);
        longint      x, y;
        logic [63:0] full;
        logic [63:0] opMask;
        opMask = (64'd1 << w) - 64'd1;
        x = longint'(64'(av) & opMask);
        y = longint'(64'(bv) & opMask);
        if (sg && av[w-1]) x = x - (longint'(1) << w);
        if (sg && bv[w-1]) y = y - (longint'(1) << w);
        full = 64'(x * y) & ((64'd1 << (2 * w)) - 64'd1);
        return full[31:0];
    endfunction

    function automatic int refLatency(input int w, input logic sg);
        return sg ? (w / 2) : (w / 2 + 1);
    endfunction

    function automatic logic readyOf(input int w);
        return (w == 8) ? inReady8 : inReady16;
    endfunction

    function automatic logic validOf(input int w);
        return (w == 8) ? outValid8 : outValid16;
    endfunction

    function automatic logic [31:0] prodOf(input int w);
        return (w == 8) ? {16'h0000, p8} : p16;
    endfunction

    // One full transaction; returns the product and cycles from accept to out_valid.
    task automatic applyStimulus(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic sg, input int stall,
                                 output logic [31:0] prod, output int lat);
        int waitCyc;
        waitCyc  = 0;
        aIn      = av;
        bIn      = bv;
        sgnIn    = sg;
        outReady = 1'b0;
        while (!readyOf(w) && waitCyc < 50) begin
            @(posedge clk); #1;
            waitCyc++;
        end
        if (waitCyc >= 50) checkOutput("in_ready_timeout", 64'(readyOf(w)), 64'd1);
        if (w == 8) inValid8 = 1'b1;
        else        inValid16 = 1'b1;
        @(posedge clk); #1;
        inValid8  = 1'b0;
        inValid16 = 1'b0;
        aIn   = 16'($urandom);
        bIn   = 16'($urandom);
        sgnIn = 1'($urandom);
        lat = 0;
        while (!validOf(w) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        prod = prodOf(w);
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
    endtask

    function automatic logic [15:0] cornerOf(input int w, input int k);
        logic [15:0] one;
        one = 16'd1;
        case (k)
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return one << (w - 1);
            default: return (one << (w - 1)) - 16'd1;
        endcase
    endfunction

    task automatic runRandom(input int w, input int count);
        logic [15:0] av, bv;
        logic        sg;
        logic [31:0] prod;
        int          lat;
        for (int i = 0; i < count; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            if ($urandom_range(0, 7) == 0) av = cornerOf(w, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) bv = cornerOf(w, int'($urandom_range(0, 3)));
            sg = 1'($urandom);
            applyStimulus(w, av, bv, sg, int'($urandom_range(0, 3)), prod, lat);
            checkOutput((w == 8) ? "rand8_product" : "rand16_product", 64'(prod), 64'(refMul(w, av, bv, sg)));
            checkOutput((w == 8) ? "rand8_latency" : "rand16_latency", 64'(lat), 64'(refLatency(w, sg)));
        end
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] prod;
        int          lat;
        logic        sawValid;

        vecs.push_back(vec_t'{8,  16'h0080, 16'h0080, 1'b1, 32'h0000_4000, 4});
        vecs.push_back(vec_t'{8,  16'h007F, 16'h00FF, 1'b1, 32'h0000_FF81, 4});
        vecs.push_back(vec_t'{8,  16'h0080, 16'h007F, 1'b1, 32'h0000_C080, 4});
        vecs.push_back(vec_t'{8,  16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01, 5});
        vecs.push_back(vec_t'{8,  16'h0080, 16'h0002, 1'b0, 32'h0000_0100, 5});
        vecs.push_back(vec_t'{8,  16'h00FF, 16'h00FF, 1'b1, 32'h0000_0001, 4});
        vecs.push_back(vec_t'{8,  16'h0000, 16'h00AB, 1'b0, 32'h0000_0000, 5});
        vecs.push_back(vec_t'{16, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 8});
        vecs.push_back(vec_t'{16, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 9});
        vecs.push_back(vec_t'{16, 16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, 8});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_in_ready8",   64'(inReady8),   64'd1);
        checkOutput("reset_out_valid8",  64'(outValid8),  64'd0);
        checkOutput("reset_p8",          64'(p8),         64'd0);
        checkOutput("reset_in_ready16",  64'(inReady16),  64'd1);
        checkOutput("reset_out_valid16", 64'(outValid16), 64'd0);
        checkOutput("reset_p16",         64'(p16),        64'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].sg, i % 3, prod, lat);
            checkOutput("vec_product", 64'(prod), 64'(vecs[i].expP));
            checkOutput("vec_latency", 64'(lat), 64'(vecs[i].expLat));
            checkOutput("vec_ready_after_hs", 64'(readyOf(vecs[i].w)), 64'd1);
        end

        // Back-pressure: product must hold while new operands are offered.
        aIn = 16'h000C; bIn = 16'h000D; sgnIn = 1'b0; inValid8 = 1'b1;
        @(posedge clk); #1;
        inValid8 = 1'b0;
        lat = 0;
        while (!outValid8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bp_latency", 64'(lat), 64'd5);
        repeat (3) begin
            inValid8 = 1'b1;
            aIn = 16'($urandom); bIn = 16'($urandom); sgnIn = 1'($urandom);
            @(posedge clk); #1;
            checkOutput("bp_p_hold",    64'(p8),        64'h009C);
            checkOutput("bp_in_ready",  64'(inReady8),  64'd0);
            checkOutput("bp_out_valid", 64'(outValid8), 64'd1);
        end
        inValid8 = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("bp_ready_after_hs", 64'(inReady8),  64'd1);
        checkOutput("bp_valid_dropped",  64'(outValid8), 64'd0);

        // Reset after two CALC edges aborts the transaction.
        aIn = 16'h0011; bIn = 16'h0022; sgnIn = 1'b1; inValid8 = 1'b1;
        @(posedge clk); #1;
        inValid8 = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        inValid8 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        inValid8 = 1'b0;
        checkOutput("abort_in_ready",  64'(inReady8),  64'd1);
        checkOutput("abort_out_valid", 64'(outValid8), 64'd0);
        checkOutput("abort_p_cleared", 64'(p8),        64'd0);
        sawValid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (outValid8) sawValid = 1'b1;
        end
        checkOutput("abort_no_output", 64'(sawValid), 64'd0);
        applyStimulus(8, 16'h0003, 16'h0005, 1'b1, 0, prod, lat);
        checkOutput("post_abort_product", 64'(prod), 64'd15);
        checkOutput("post_abort_latency", 64'(lat),  64'd4);

        runRandom(8, 2000);
        runRandom(16, 2000);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
